// File: rtl/sparc_ifu_repl_pkg.sv
// Shared definitions for the icache fill replacement controller:
// FSM state encoding, way count, LFSR reset seed and the LFSR step function.
package sparc_ifu_repl_pkg;

  localparam int         NWAYS     = 4;
  localparam logic [4:0] LFSR_SEED = 5'h1F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } repl_state_t;

  // One step of the 5-bit replacement LFSR (taps at bits 4 and 1).
  function automatic logic [4:0] lfsr_step(input logic [4:0] l);
    return {l[3:0], l[1] ^ l[4]};
  endfunction

endpackage

// File: rtl/dff_s.sv
// Scan flop cell: synchronous reset to RST_VAL, scan shift when se is high
// (shifting si in at bit 0, bit SIZE-1 drives so), functional load otherwise.
module dff_s #(
  parameter int              SIZE    = 1,
  parameter logic [SIZE-1:0] RST_VAL = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            se,
  input  logic            si,
  input  logic [SIZE-1:0] din,
  output logic [SIZE-1:0] q,
  output logic            so
);

  logic [SIZE-1:0] shift_d;

  generate
    if (SIZE == 1) begin : g_one
      assign shift_d = si;
    end else begin : g_multi
      assign shift_d = {q[SIZE-2:0], si};
    end
  endgenerate

  // Reset has priority over scan shift, scan shift over functional load.
  always_ff @(posedge clk) begin
    if (reset)   q <= RST_VAL;
    else if (se) q <= shift_d;
    else         q <= din;
  end

  assign so = q[SIZE-1];

endmodule

// File: rtl/sparc_ifu_repl_lfsr.sv
// 5-bit replacement LFSR. Holds its value unless advance is high, reloads
// SEED on reset, and presents the pseudo-random way {lfsr[0], lfsr[2]}.
module sparc_ifu_repl_lfsr
  import sparc_ifu_repl_pkg::*;
#(
  parameter logic [4:0] SEED = LFSR_SEED
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       se,
  input  logic       si,
  output logic       so,
  input  logic       advance,
  output logic [1:0] way,
  output logic [4:0] lfsr
);

  logic [4:0] lfsr_d;

  // Step only when the caller consumes a random choice.
  always_comb begin
    lfsr_d = advance ? lfsr_step(lfsr) : lfsr;
  end

  dff_s #(.SIZE(5), .RST_VAL(SEED)) u_lfsr_reg (
    .clk   (clk),
    .reset (reset),
    .se    (se),
    .si    (si),
    .din   (lfsr_d),
    .q     (lfsr),
    .so    (so)
  );

  assign way = {lfsr[0], lfsr[2]};

endmodule

// File: rtl/sparc_ifu_repl_ctl.sv
// Icache fill replacement controller. Captures one fill request at a time,
// picks a victim way (lowest invalid way, else LFSR choice), drives the array
// write handshake and pulses fill_done when the write is accepted.
// Optional feature macro: SPARC_IFU_REPL_LOCK_EN adds lock_mask, which removes
// locked ways from both invalid-way priority and random selection.
// Scan chain order: si -> lfsr -> state -> captured valids -> wr_idx -> wr_way
// -> control outputs -> so.
module sparc_ifu_repl_ctl
  import sparc_ifu_repl_pkg::*;
#(
  parameter int         NWAYS     = sparc_ifu_repl_pkg::NWAYS,
  parameter int         IDX_W     = 7,
  parameter logic [4:0] LFSR_SEED = sparc_ifu_repl_pkg::LFSR_SEED
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             se,
  input  logic             si,
  output logic             so,
  input  logic             fill_req,
  input  logic [IDX_W-1:0] fill_idx,
  input  logic [NWAYS-1:0] way_vld,
  output logic             fill_ack,
  output logic             busy,
  output logic             wr_req,
  output logic [IDX_W-1:0] wr_idx,
  output logic [1:0]       wr_way,
  input  logic             wr_ack,
  output logic             fill_done
`ifdef SPARC_IFU_REPL_LOCK_EN
  ,
  input  logic [NWAYS-1:0] lock_mask
`endif
);

  repl_state_t      state_q, state_d;
  logic [1:0]       state_raw;
  logic [NWAYS-1:0] cap_vld_q, cap_vld_d;
  logic [NWAYS-1:0] eff_lock, free_ways;
  logic [IDX_W-1:0] wr_idx_d;
  logic [1:0]       wr_way_d, rnd_way, sel_way;
  logic [4:0]       lfsr_q;
  logic [3:0]       ctl_d, ctl_q;
  logic             has_free, lfsr_adv, capture;
  logic             so_lfsr, so_state, so_vld, so_idx, so_way;

  // Lowest-numbered way whose bit is set in free.
  function automatic logic [1:0] lowest_free(input logic [NWAYS-1:0] free);
    lowest_free = 2'd0;
    for (int i = NWAYS - 1; i >= 0; i--) begin
      if (free[i]) lowest_free = 2'(i);
    end
  endfunction

  // First unlocked way at or above start, wrapping from the top way to 0.
  function automatic logic [1:0] first_unlocked(input logic [1:0]       start,
                                                input logic [NWAYS-1:0] lk);
    logic [1:0] w;
    first_unlocked = start;
    for (int k = NWAYS - 1; k >= 0; k--) begin
      w = start + 2'(k);
      if (!lk[w]) first_unlocked = w;
    end
  endfunction

  assign state_q = repl_state_t'(state_raw);

`ifdef SPARC_IFU_REPL_LOCK_EN
  // A fully locked set behaves as if nothing were locked.
  assign eff_lock = (&lock_mask) ? '0 : lock_mask;
`else
  assign eff_lock = '0;
`endif

  assign free_ways = ~cap_vld_q & ~eff_lock;
  assign has_free  = |free_ways;
  assign capture   = (state_q == IDLE) && fill_req;
  assign lfsr_adv  = (state_q == SEL) && !has_free;

  // Victim choice: invalid way first, otherwise the LFSR way nudged past locks.
  always_comb begin
    sel_way = has_free ? lowest_free(free_ways) : first_unlocked(rnd_way, eff_lock);
  end

  // Next state, next registered control outputs and datapath loads.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fill_req) state_d = SEL;
      SEL:     state_d = WR;
      WR:      if (wr_ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ctl_d     = {capture, state_d != IDLE, state_d == WR, state_d == DONE};
    wr_idx_d  = capture ? fill_idx : wr_idx;
    cap_vld_d = capture ? way_vld : cap_vld_q;
    wr_way_d  = (state_q == SEL) ? sel_way : wr_way;
  end

  // ---- register stage ----
  sparc_ifu_repl_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .se      (se),
    .si      (si),
    .so      (so_lfsr),
    .advance (lfsr_adv),
    .way     (rnd_way),
    .lfsr    (lfsr_q)
  );

  dff_s #(.SIZE(2), .RST_VAL(IDLE)) u_state_reg (
    .clk(clk), .reset(reset), .se(se), .si(so_lfsr),
    .din(state_d), .q(state_raw), .so(so_state)
  );

  // Captured valid bits are pure data and need no reset.
  dff_s #(.SIZE(NWAYS)) u_vld_reg (
    .clk(clk), .reset(1'b0), .se(se), .si(so_state),
    .din(cap_vld_d), .q(cap_vld_q), .so(so_vld)
  );

  dff_s #(.SIZE(IDX_W)) u_idx_reg (
    .clk(clk), .reset(reset), .se(se), .si(so_vld),
    .din(wr_idx_d), .q(wr_idx), .so(so_idx)
  );

  dff_s #(.SIZE(2)) u_way_reg (
    .clk(clk), .reset(reset), .se(se), .si(so_idx),
    .din(wr_way_d), .q(wr_way), .so(so_way)
  );

  dff_s #(.SIZE(4)) u_ctl_reg (
    .clk(clk), .reset(reset), .se(se), .si(so_way),
    .din(ctl_d), .q(ctl_q), .so(so)
  );

  assign {fill_ack, busy, wr_req, fill_done} = ctl_q;

endmodule

// File: tb/tb_sparc_ifu_repl_ctl.sv
// Directed bench for sparc_ifu_repl_ctl with a transaction-level reference
// model and literal expectations for the replacement sequence.
module tb_sparc_ifu_repl_ctl;

  logic       clk = 1'b0;
  logic       reset, se, si, so;
  logic       fill_req, fill_ack, busy, wr_req, wr_ack, fill_done;
  logic [6:0] fill_idx, wr_idx;
  logic [3:0] way_vld;
  logic [1:0] wr_way;
`ifdef SPARC_IFU_REPL_LOCK_EN
  logic [3:0] lock_mask;
`endif

  always #5 clk = ~clk;

  sparc_ifu_repl_ctl dut (
    .clk       (clk),
    .reset     (reset),
    .se        (se),
    .si        (si),
    .so        (so),
    .fill_req  (fill_req),
    .fill_idx  (fill_idx),
    .way_vld   (way_vld),
    .fill_ack  (fill_ack),
    .busy      (busy),
    .wr_req    (wr_req),
    .wr_idx    (wr_idx),
    .wr_way    (wr_way),
    .wr_ack    (wr_ack),
    .fill_done (fill_done)
`ifdef SPARC_IFU_REPL_LOCK_EN
    ,
    .lock_mask (lock_mask)
`endif
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] eff_lock(input logic [3:0] lk);
    return (lk == 4'hF) ? 4'h0 : lk;
  endfunction

  function automatic bit any_free(input logic [3:0] vld, input logic [3:0] lk);
    logic [3:0] el;
    el = eff_lock(lk);
    return ((~vld & ~el) != 4'h0);
  endfunction

  function automatic int victim(input logic [3:0] vld, input logic [3:0] lk,
                                input logic [4:0] l);
    logic [3:0] el;
    int r, w;
    el = eff_lock(lk);
    for (int i = 0; i < 4; i++) if (!vld[i] && !el[i]) return i;
    r = int'(l[0]) * 2 + int'(l[2]);
    for (int k = 0; k < 4; k++) begin
      w = (r + k) % 4;
      if (!el[w]) return w;
    end
    return r;
  endfunction

  function automatic logic [4:0] next_lfsr(input logic [4:0] l);
    int v;
    v = int'(l);
    return 5'(((v << 1) & 30) | (((v >> 1) ^ (v >> 4)) & 1));
  endfunction

  int         m_phase;   // 0 idle, 1 choosing, 2 writing, 3 completing
  bit         m_ack, m_busy, m_wrreq, m_done, m_pin;
  logic [6:0] m_idx;
  logic [1:0] m_way;
  logic [4:0] m_lfsr;
  logic [3:0] m_vld;

  always @(posedge clk) begin : model
    logic [3:0] lk;
`ifdef SPARC_IFU_REPL_LOCK_EN
    lk = lock_mask;
`else
    lk = 4'h0;
`endif
    if (reset) begin
      m_phase = 0; m_ack = 0; m_done = 0; m_lfsr = 5'h1F;
      m_idx = 7'h0; m_way = 2'd0; m_pin = 1;
    end else begin
      m_ack = 0; m_done = 0;
      case (m_phase)
        0: if (fill_req) begin
             m_idx = fill_idx; m_vld = way_vld; m_ack = 1; m_phase = 1; m_pin = 0;
           end
        1: begin
             m_way = 2'(victim(m_vld, lk, m_lfsr));
             if (!any_free(m_vld, lk)) m_lfsr = next_lfsr(m_lfsr);
             m_phase = 2;
           end
        2: if (wr_ack) begin m_phase = 3; m_done = 1; end
        default: m_phase = 0;
      endcase
    end
    m_busy  = (m_phase != 0);
    m_wrreq = (m_phase == 2);
  end

  // Every-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("m_fill_ack",  fill_ack,  m_ack);
      chk("m_busy",      busy,      m_busy);
      chk("m_wr_req",    wr_req,    m_wrreq);
      chk("m_fill_done", fill_done, m_done);
      chk("m_lfsr",      dut.lfsr_q, m_lfsr);
      if (m_pin || m_phase == 2) begin
        chk("m_wr_idx", wr_idx, m_idx);
        chk("m_wr_way", wr_way, m_way);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    reset = 1'b1; fill_req = 1'b0; wr_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    reset = 1'b0;
  endtask

  task automatic do_fill(input logic [6:0] idx, input logic [3:0] vld,
                         input int ack_delay, output logic [1:0] way);
    int n;
    fill_idx = idx; way_vld = vld; fill_req = 1'b1; n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fill_ack && n < 20);
    chk("ack_seen", fill_ack, 1);
    chk("ack_latency", n, 1);
    fill_req = 1'b0; way_vld = ~vld; fill_idx = ~idx;
    @(negedge clk);
    for (int i = 0; i < ack_delay; i++) begin
      chk("wr_req_hold", wr_req, 1);
      chk("wr_idx_hold", wr_idx, idx);
      @(negedge clk);
    end
    way = wr_way;
    chk("wr_req", wr_req, 1);
    chk("wr_idx", wr_idx, idx);
    wr_ack = 1'b1;
    @(negedge clk);
    chk("fill_done", fill_done, 1);
    chk("way_after_ack", wr_way, way);
    wr_ack = 1'b0;
    @(negedge clk);
    chk("done_clear", fill_done, 0);
    chk("busy_drop", busy, 0);
  endtask

  logic [1:0] w;
  int acks, dones, done1, ack2;

  initial begin
    reset = 1'b1; se = 1'b0; si = 1'b0; fill_req = 1'b0; wr_ack = 1'b0;
    fill_idx = 7'h0; way_vld = 4'h0;
`ifdef SPARC_IFU_REPL_LOCK_EN
    lock_mask = 4'h0;
`endif

    // Reset state.
    do_reset();
    chk("rst_fill_ack", fill_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_req", wr_req, 0);
    chk("rst_fill_done", fill_done, 0);
    chk("rst_wr_idx", wr_idx, 0);
    chk("rst_wr_way", wr_way, 0);
    chk("rst_lfsr", dut.lfsr_q, 5'h1F);

    // Invalid way present: way 2 chosen, LFSR untouched.
    do_fill(7'h15, 4'b1011, 0, w);
    chk("t1_way", w, 2);
    chk("t1_lfsr", dut.lfsr_q, 5'h1F);

    // All ways valid: random sequence 3,1,1,2.
    do_reset();
    do_fill(7'h01, 4'b1111, 0, w); chk("t2_way0", w, 3); chk("t2_lfsr0", dut.lfsr_q, 5'h1E);
    do_fill(7'h02, 4'b1111, 0, w); chk("t2_way1", w, 1); chk("t2_lfsr1", dut.lfsr_q, 5'h1C);
    do_fill(7'h03, 4'b1111, 0, w); chk("t2_way2", w, 1); chk("t2_lfsr2", dut.lfsr_q, 5'h19);
    do_fill(7'h04, 4'b1111, 0, w); chk("t2_way3", w, 2); chk("t2_lfsr3", dut.lfsr_q, 5'h13);

    // Slow array: wr_ack held off for 5 cycles; lowest invalid is way 0.
    do_fill(7'h6A, 4'b0000, 5, w);
    chk("t3_way", w, 0);

    // Stray wr_ack while idle must not start or finish anything.
    wr_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_busy", busy, 0);
      chk("stray_done", fill_done, 0);
    end
    wr_ack = 1'b0;
    @(negedge clk);

    // Request held continuously, array acking immediately.
    fill_idx = 7'h33; way_vld = 4'b1101; fill_req = 1'b1; wr_ack = 1'b1;
    acks = 0; dones = 0; done1 = -1; ack2 = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (fill_ack) begin
        acks++;
        if (acks == 2) ack2 = k;
      end
      if (fill_done) begin
        dones++;
        if (dones == 1) done1 = k;
      end
    end
    fill_req = 1'b0; wr_ack = 1'b0;
    chk("b2b_acks", acks, 3);
    chk("b2b_dones", dones, 3);
    chk("b2b_ack_after_done", (ack2 > done1) ? 1 : 0, 1);
    @(negedge clk);

    // Reset in the middle of a write aborts it.
    do_reset();
    fill_idx = 7'h2A; way_vld = 4'hF; fill_req = 1'b1;
    @(negedge clk);
    chk("abort_ack", fill_ack, 1);
    fill_req = 1'b0;
    @(negedge clk);
    chk("abort_in_wr", wr_req, 1);
    chk("abort_lfsr_adv", dut.lfsr_q, 5'h1E);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_wr_req", wr_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", fill_done, 0);
    chk("abort_lfsr", dut.lfsr_q, 5'h1F);
    @(negedge clk);
    chk("abort_no_done", fill_done, 0);

`ifdef SPARC_IFU_REPL_LOCK_EN
    // Random way 3 locked: wrap to way 0.
    do_reset();
    lock_mask = 4'b1000;
    do_fill(7'h11, 4'b1111, 0, w);
    chk("lk_wrap_way", w, 0);
    chk("lk_wrap_lfsr", dut.lfsr_q, 5'h1E);
    // Everything locked: lock ignored.
    do_reset();
    lock_mask = 4'b1111;
    do_fill(7'h12, 4'b1111, 0, w);
    chk("lk_all_way", w, 3);
    // Only invalid way is locked: falls to random choice.
    do_reset();
    lock_mask = 4'b0100;
    do_fill(7'h13, 4'b1011, 0, w);
    chk("lk_inv_way", w, 3);
    chk("lk_inv_lfsr", dut.lfsr_q, 5'h1E);
    lock_mask = 4'b0000;
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
